// File: rtl/tx_stream_mux.sv
// Merges command-parser response frames and buffered UART bytes into one TX FIFO byte stream.
// UART bytes go out as packets: HDR_BYTE, UART_TYPE, len, then len payload bytes.
module tx_stream_mux #(
    parameter int         BUF_DEPTH    = 16,
    parameter int         IDLE_TIMEOUT = 1000,
    parameter logic [7:0] HDR_BYTE     = 8'hA5,
    parameter logic [7:0] UART_TYPE    = 8'h55
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       par_valid,
    input  logic [7:0] par_data,
    input  logic       par_last,
    output logic       par_ready,
    input  logic       uart_valid,
    input  logic [7:0] uart_data,
    output logic       uart_drop,
    input  logic       fifo_wfull,
    output logic       fifo_winc,
    output logic [7:0] fifo_wdata,
    output logic       busy
);
    localparam int AW = $clog2(BUF_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {S_IDLE, S_PAR, S_U_HDR, S_U_TYPE, S_U_LEN, S_U_PAY} state_t;
    typedef enum logic {G_PAR, G_UART} grant_t;

    logic [7:0]    buf_mem [BUF_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [15:0]   idle_cnt;
    state_t        state;
    grant_t        last_grant;
    logic [7:0]    len;
    logic [7:0]    pay_left;

    logic       buf_full;
    logic       buf_wr;
    logic       buf_rd;
    logic       flush_req;
    logic       out_valid;
    logic [7:0] out_data;

    assign buf_full  = (count == CW'(BUF_DEPTH));
    assign buf_wr    = uart_valid && !buf_full;
    assign flush_req = buf_full || (count != '0 && idle_cnt == 16'(IDLE_TIMEOUT));

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        out_valid = 1'b0;
        out_data  = 8'h00;
        par_ready = 1'b0;
        case (state)
            S_PAR: begin
                par_ready = !fifo_wfull;
                out_valid = par_valid;
                out_data  = par_data;
            end
            S_U_HDR: begin
                out_valid = 1'b1;
                out_data  = HDR_BYTE;
            end
            S_U_TYPE: begin
                out_valid = 1'b1;
                out_data  = UART_TYPE;
            end
            S_U_LEN: begin
                out_valid = 1'b1;
                out_data  = len;
            end
            S_U_PAY: begin
                out_valid = 1'b1;
                out_data  = buf_mem[rd_ptr];
            end
            default: ;
        endcase
    end

    // The full flag gates the write strobe directly so a full FIFO never sees winc.
    assign fifo_winc  = out_valid && !fifo_wfull;
    assign fifo_wdata = out_data;
    assign busy       = (state != S_IDLE);
    assign buf_rd     = (state == S_U_PAY) && fifo_winc;

    // NOTE: buffer storage has no reset; only pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (buf_wr) buf_mem[wr_ptr] <= uart_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            idle_cnt  <= '0;
            uart_drop <= 1'b0;
        end else begin
            uart_drop <= uart_valid && buf_full;
            if (buf_wr) wr_ptr <= wr_ptr + 1'b1;
            if (buf_rd) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(buf_wr) - CW'(buf_rd);
            if (buf_wr)
                idle_cnt <= '0;
            else if (count != '0 && idle_cnt != 16'(IDLE_TIMEOUT))
                idle_cnt <= idle_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            last_grant <= G_UART;
            len        <= '0;
            pay_left   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // Round-robin: a pending parser frame wins if UART went last.
                    if (flush_req && (last_grant == G_PAR || !par_valid)) begin
                        state <= S_U_HDR;
                        len   <= 8'(count);
                    end else if (par_valid) begin
                        state <= S_PAR;
                    end
                end
                S_PAR: begin
                    if (fifo_winc && par_last) begin
                        state      <= S_IDLE;
                        last_grant <= G_PAR;
                    end
                end
                S_U_HDR:  if (fifo_winc) state <= S_U_TYPE;
                S_U_TYPE: if (fifo_winc) state <= S_U_LEN;
                S_U_LEN: begin
                    if (fifo_winc) begin
                        state    <= S_U_PAY;
                        pay_left <= len;
                    end
                end
                S_U_PAY: begin
                    if (fifo_winc) begin
                        pay_left <= pay_left - 8'd1;
                        if (pay_left == 8'd1) begin
                            state      <= S_IDLE;
                            last_grant <= G_UART;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tx_stream_mux.sv
// Self-checking bench for tx_stream_mux: directed scenarios plus randomized traffic,
// checked by parsing the TX byte stream against queues of sent parser frames and UART bytes.
module tb_tx_stream_mux;
    localparam int         DEPTH = 16;
    localparam int         TMO   = 1000;
    localparam logic [7:0] HDR   = 8'hA5;
    localparam logic [7:0] TYP   = 8'h55;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       par_valid, par_last, par_ready;
    logic [7:0] par_data;
    logic       uart_valid, uart_drop;
    logic [7:0] uart_data;
    logic       fifo_wfull, fifo_winc;
    logic [7:0] fifo_wdata;
    logic       busy;

    tx_stream_mux dut (
        .clk(clk), .rst_n(rst_n),
        .par_valid(par_valid), .par_data(par_data), .par_last(par_last), .par_ready(par_ready),
        .uart_valid(uart_valid), .uart_data(uart_data), .uart_drop(uart_drop),
        .fifo_wfull(fifo_wfull), .fifo_winc(fifo_winc), .fifo_wdata(fifo_wdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int drops    = 0;
    int viol     = 0;
    int wfull_mode = 0;   // 0: driven by main flow, 1: random, 2: toggle each cycle

    logic [7:0] got[$];
    logic [7:0] uart_exp[$];
    logic [7:0] par_exp[$];
    bit         par_lst[$];

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Observe the FIFO write port away from the active edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (fifo_winc) got.push_back(fifo_wdata);
            if (fifo_winc && fifo_wfull) viol++;
            if (uart_drop) drops++;
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (wfull_mode == 1) fifo_wfull = ($urandom_range(0, 3) == 0);
        else if (wfull_mode == 2) fifo_wfull = ~fifo_wfull;
    end

    task automatic send_uart(input logic [7:0] b);
        uart_valid = 1'b1;
        uart_data  = b;
        @(posedge clk);
        #1;
        uart_valid = 1'b0;
        uart_data  = 8'($urandom);
    endtask

    task automatic drive_frame(input int n);
        for (int k = 0; k < n; k++) begin
            logic [7:0] b;
            bit         done;
            int         budget;
            b = 8'($urandom);
            if (b == HDR) b = 8'h5A;
            par_exp.push_back(b);
            par_lst.push_back(k == n - 1);
            par_valid = 1'b1;
            par_data  = b;
            par_last  = (k == n - 1);
            done   = 1'b0;
            budget = 0;
            while (!done) begin
                @(negedge clk);
                done = par_ready;
                @(posedge clk);
                #1;
                budget++;
                if (!done && budget > 3000) begin
                    check("par_handshake_timeout", 0, 1);
                    done = 1'b1;
                end
            end
        end
        par_valid = 1'b0;
        par_last  = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input int budget, input string tag);
        int c = 0;
        while (got.size() < n && c < budget) begin
            @(negedge clk);
            #1;
            c++;
        end
        if (got.size() < n) check(tag, got.size(), n);
    endtask

    // Parse the collected stream: parser frames must appear whole and in order,
    // UART packets must carry the accepted UART bytes in arrival order.
    task automatic verify_stream(input string tag);
        int  i = 0;
        bit  in_frame = 1'b0;
        while (i < got.size()) begin
            if (!in_frame && got[i] == HDR) begin
                int len;
                if (i + 2 >= got.size()) begin
                    check({tag, "_pkt_trunc"}, 0, 1);
                    break;
                end
                check({tag, "_type"}, got[i+1], TYP);
                len = int'(got[i+2]);
                check({tag, "_len_range"}, (len >= 1 && len <= DEPTH), 1);
                if (i + 3 + len > got.size()) begin
                    check({tag, "_pay_trunc"}, 0, 1);
                    break;
                end
                for (int k = 0; k < len; k++) begin
                    if (uart_exp.size() == 0) check({tag, "_uart_extra"}, 0, 1);
                    else check({tag, "_uart_pay"}, got[i+3+k], uart_exp.pop_front());
                end
                i += 3 + len;
            end else begin
                if (par_exp.size() == 0) begin
                    check({tag, "_par_extra"}, 0, 1);
                end else begin
                    check({tag, "_par_byte"}, got[i], par_exp.pop_front());
                    in_frame = !par_lst.pop_front();
                end
                i++;
            end
        end
        check({tag, "_uart_left"}, uart_exp.size(), 0);
        check({tag, "_par_left"}, par_exp.size(), 0);
        got.delete();
        uart_exp.delete();
        par_exp.delete();
        par_lst.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        logic [7:0] first;
        int         c;

        rst_n = 1'b0; par_valid = 1'b0; par_last = 1'b0; par_data = 8'h00;
        uart_valid = 1'b0; uart_data = 8'h00; fifo_wfull = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_winc", fifo_winc, 0);
        check("rst_par_ready", par_ready, 0);
        check("rst_drop", uart_drop, 0);
        check("rst_wdata", fifo_wdata, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Partial buffer flushed by the idle timeout.
        foreach (uart_exp[i]) ;
        uart_exp.push_back(8'h11); send_uart(8'h11);
        uart_exp.push_back(8'h22); send_uart(8'h22);
        uart_exp.push_back(8'h33); send_uart(8'h33);
        repeat (TMO - 20) @(posedge clk);
        #1;
        check("s1_no_early_flush", got.size(), 0);
        wait_bytes(6, 200, "s1_timeout");
        repeat (5) @(posedge clk);
        #1;
        check("s1_count", got.size(), 6);
        if (got.size() >= 3) check("s1_len", got[2], 8'h03);
        verify_stream("s1");

        // Full buffer with FIFO blocked: the 17th byte is dropped.
        fifo_wfull = 1'b1;
        for (int k = 0; k < DEPTH + 1; k++) begin
            b = 8'($urandom);
            if (k < DEPTH) uart_exp.push_back(b);
            send_uart(b);
        end
        repeat (4) @(posedge clk);
        #1;
        check("s2_drop_pulses", drops, 1);
        check("s2_no_write_while_full", got.size(), 0);
        fifo_wfull = 1'b0;
        wait_bytes(DEPTH + 3, 100, "s2_timeout");
        repeat (5) @(posedge clk);
        #1;
        check("s2_count", got.size(), DEPTH + 3);
        if (got.size() >= 3) check("s2_len", got[2], 8'(DEPTH));
        verify_stream("s2");
        drops = 0;

        // Parser frame contends with a UART flush after UART went last: parser first.
        for (int k = 0; k < DEPTH; k++) begin
            b = 8'($urandom);
            uart_exp.push_back(b);
            send_uart(b);
        end
        drive_frame(4);
        first = par_exp[0];
        wait_bytes(4 + 3 + DEPTH, 200, "s3_timeout");
        repeat (5) @(posedge clk);
        #1;
        if (got.size() >= 5) begin
            check("s3_par_first", got[0], first);
            check("s3_hdr_after_frame", got[4], HDR);
        end
        verify_stream("s3");

        // FIFO full toggling every cycle while the packet drains.
        for (int k = 0; k < 8; k++) begin
            b = 8'($urandom);
            uart_exp.push_back(b);
            send_uart(b);
        end
        wfull_mode = 2;
        wait_bytes(11, TMO + 300, "s4_timeout");
        repeat (5) @(posedge clk);
        #1;
        wfull_mode = 0;
        fifo_wfull = 1'b0;
        check("s4_count", got.size(), 11);
        verify_stream("s4");

        // Reset mid-payload abandons the packet at once.
        for (int k = 0; k < 5; k++) send_uart(8'($urandom));
        wait_bytes(5, TMO + 300, "s5_timeout");
        #1;
        check("s5_busy_before_rst", busy, 1);
        rst_n = 1'b0;
        #1;
        check("s5_rst_busy", busy, 0);
        check("s5_rst_winc", fifo_winc, 0);
        check("s5_rst_wdata", fifo_wdata, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        got.delete();
        uart_exp.push_back(8'h3C); send_uart(8'h3C);
        uart_exp.push_back(8'hC3); send_uart(8'hC3);
        wait_bytes(5, TMO + 300, "s5_after_timeout");
        repeat (5) @(posedge clk);
        #1;
        check("s5_count", got.size(), 5);
        if (got.size() >= 3) check("s5_len", got[2], 8'h02);
        verify_stream("s5");
        check("drops_directed", drops, 0);

        // Randomized mixed traffic with random FIFO backpressure.
        wfull_mode = 1;
        fork
            begin
                for (int n = 0; n < 60; n++) begin
                    logic [7:0] rb;
                    repeat ($urandom_range(30, 60)) @(posedge clk);
                    #1;
                    rb = 8'($urandom);
                    uart_exp.push_back(rb);
                    send_uart(rb);
                end
            end
            begin
                for (int n = 0; n < 12; n++) begin
                    int gap;
                    gap = $urandom_range(50, 200);
                    for (int g = 0; g < gap; g++) begin
                        @(posedge clk);
                        #1;
                        par_last = 1'($urandom_range(0, 1));
                        par_data = 8'($urandom);
                    end
                    drive_frame($urandom_range(1, 4));
                end
            end
        join
        repeat (TMO + 100) @(posedge clk);
        c = 0;
        while (busy && c < 500) begin
            @(posedge clk);
            c++;
        end
        #1;
        check("rand_idle_at_end", busy, 0);
        verify_stream("rand");
        check("drops_random", drops, 0);
        check("winc_while_full", viol, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
